// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^M) power unit.
//   gf_state_t      : sequencer states (IDLE/RUN/DONE)
//   GF_POLY_DEFAULT : default reduction polynomial x^8+x^4+x^3+x^2+1
//   GF_ALPHA        : field generator value (the polynomial x)
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_t;

  localparam logic [8:0]  GF_POLY_DEFAULT = 9'h11D;
  localparam int unsigned GF_ALPHA        = 2;

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^M) multiplier: p = a * b mod POLY.
//   a, b : M-bit field elements
//   p    : M-bit product
// Shift-and-add: a is multiplied by x once per bit of b, reducing by
// POLY whenever the top bit would overflow.
module gf_mul #(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11D
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  localparam logic [M-1:0] RED = POLY[M-1:0];

  logic [M-1:0] a_sh;

  always_comb begin
    p    = '0;
    a_sh = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) p = p ^ a_sh;
      a_sh = {a_sh[M-2:0], 1'b0} ^ (a_sh[M-1] ? RED : '0);
    end
  end

endmodule

// File: rtl/gf_pow_seq.sv
// Sequential GF(2^M) exponentiation: out_data = base^exp (or alpha^exp),
// MSB-first square-and-multiply, one exponent bit per clock.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : request handshake (in_ready = state is IDLE)
//   in_base, in_exp      : operands; in_base ignored when in_alpha=1
//   in_alpha             : use generator (2) as base
//   out_valid/out_ready  : result handshake, out_data held while stalled
//   out_data             : result
//   busy                 : high in RUN or DONE
// Optional build macro GF_POW_ZERO_SKIP_EN: skip leading zero exponent
// bits on accept, making latency equal to the exponent bit length (min 1).
module gf_pow_seq
  import gf_pkg::*;
#(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = GF_POLY_DEFAULT,
  parameter int         EW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  in_base,
  input  logic [EW-1:0] in_exp,
  input  logic          in_alpha,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic          busy
);

  localparam int CW = $clog2(EW + 1);

  gf_state_t      state;
  logic [M-1:0]   b;
  logic [M-1:0]   acc;
  logic [EW-1:0]  e;
  logic [CW-1:0]  cnt;

  logic [M-1:0]   acc_sq;
  logic [M-1:0]   acc_mul;
  logic [M-1:0]   acc_next;

  gf_mul #(.M(M), .POLY(POLY)) u_sq (
    .a (acc),
    .b (acc),
    .p (acc_sq)
  );

  gf_mul #(.M(M), .POLY(POLY)) u_mul (
    .a (acc_sq),
    .b (b),
    .p (acc_mul)
  );

  assign acc_next = e[EW-1] ? acc_mul : acc_sq;
  assign in_ready = (state == IDLE);

  logic [EW-1:0] start_e;
  logic [CW-1:0] start_cnt;

`ifdef GF_POW_ZERO_SKIP_EN
  logic [CW-1:0] lz;
  logic          found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < EW; i++) begin
      if (!found) begin
        if (in_exp[EW-1-i]) found = 1'b1;
        else                lz    = lz + 1'b1;
      end
    end
  end

  // exp=0 still runs one squaring of 1, so it takes a single edge
  // and flows through the normal RUN->DONE path.
  assign start_e   = in_exp << lz;
  assign start_cnt = (in_exp == '0) ? CW'(1) : CW'(EW) - lz;
`else
  assign start_e   = in_exp;
  assign start_cnt = CW'(EW);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      b         <= '0;
      acc       <= '0;
      e         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            b     <= in_alpha ? M'(GF_ALPHA) : in_base;
            e     <= start_e;
            cnt   <= start_cnt;
            acc   <= M'(1);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          e   <= e << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_pow_seq.sv
// Directed testbench for gf_pow_seq (M=8, POLY=0x11D, EW=8).
// Expected results are hand-computed powers in GF(256).
module tb_gf_pow_seq;

  localparam int M  = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_base;
  logic [EW-1:0] in_exp;
  logic          in_alpha;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_data;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;

  gf_pow_seq #(.M(M), .POLY(9'h11D), .EW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_exp    (in_exp),
    .in_alpha  (in_alpha),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic int exp_lat(input logic [7:0] ex);
`ifdef GF_POW_ZERO_SKIP_EN
    int n;
    n = 1;
    for (int i = 0; i < 8; i++) if (ex[i]) n = i + 1;
    return n;
`else
    return EW;
`endif
  endfunction

  task automatic start(input string tag, input logic [7:0] base, input logic [7:0] ex,
                       input logic alpha);
    @(negedge clk);
    check({tag, "_ready_pre"}, in_ready, 1);
    in_valid = 1'b1;
    in_base  = base;
    in_exp   = ex;
    in_alpha = alpha;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_base  = 8'hA5;
    in_exp   = 8'h5A;
    in_alpha = 1'b0;
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_result(input string tag, input logic [7:0] want, input int want_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, want_lat);
    check({tag, "_data"}, out_data, want);
  endtask

  task automatic finish_hs(input string tag);
    int h0;
    h0 = hs_cnt;
    @(posedge clk);
    #1;
    check({tag, "_vld_clr"}, out_valid, 0);
    check({tag, "_ready_post"}, in_ready, 1);
    check({tag, "_hs"}, hs_cnt - h0, 1);
  endtask

  task automatic op(input string tag, input logic [7:0] base, input logic [7:0] ex,
                    input logic alpha, input logic [7:0] want);
    start(tag, base, ex, alpha);
    wait_result(tag, want, exp_lat(ex));
    finish_hs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    int h0;
    int pulses;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_base   = '0;
    in_exp    = '0;
    in_alpha  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_busy",      busy,      0);
    @(negedge clk);
    rst = 1'b0;

    op("a10",   8'h00, 8'h10, 1'b1, 8'h4C);
    op("b3e3",  8'h03, 8'h03, 1'b0, 8'h0F);
    op("b3e2",  8'h03, 8'h02, 1'b0, 8'h05);
    op("z0e0",  8'h00, 8'h00, 1'b0, 8'h01);
    op("z0e5",  8'h00, 8'h05, 1'b0, 8'h00);
    op("aFF",   8'h00, 8'hFF, 1'b1, 8'h01);
    op("a08",   8'h00, 8'h08, 1'b1, 8'h1D);
    op("a03",   8'h00, 8'h03, 1'b1, 8'h08);
    op("a00",   8'h00, 8'h00, 1'b1, 8'h01);
    op("b57e1", 8'h57, 8'h01, 1'b0, 8'h57);

    // backpressure: result held for 5 cycles while in_valid toggles
    out_ready = 1'b0;
    h0 = hs_cnt;
    start("bp", 8'h03, 8'h03, 1'b0);
    wait_result("bp", 8'h0F, exp_lat(8'h03));
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_base  = 8'h77;
      in_exp   = 8'h01;
      @(posedge clk);
      #1;
      check("bp_vld_hold",  out_valid, 1);
      check("bp_data_hold", out_data,  held);
      check("bp_ready_low", in_ready,  0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_hs("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_extra_busy", busy, 0);
    check("bp_one_hs", hs_cnt - h0, 1);

    // reset in the middle of RUN aborts with no output pulse
    start("ab", 8'h00, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ab_vld",   out_valid, 0);
    check("ab_busy",  busy,      0);
    check("ab_ready", in_ready,  1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < EW + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("ab_no_pulse", pulses, 0);
    op("a09", 8'h00, 8'h09, 1'b1, 8'h3A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gf_pow_seq.md
Name: gf_pow_seq

Overview:
- Sequential GF(2^M) exponentiation unit. Computes base^exp, or alpha^exp when the generator mode is selected.
- Uses MSB-first square-and-multiply, one exponent bit per clock.
- Successor to the combinational 8-bit GF exponent block; generalised in field width, reduction polynomial and exponent width.
- Adds valid/ready handshakes, a generator/arbitrary-base mode, and backpressure.
- Sits between RS/BCH syndrome/Chien logic and table-free power computation.

Parameters:
- M, 8, field width in bits (legal 3..16).
- POLY, 9'h11D, primitive reduction polynomial, M+1 bits, bit M set.
- EW, 8, exponent width in bits (≥1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_base  in  M  base operand; ignored when in_alpha=1
- in_exp  in  EW  exponent, unsigned
- in_alpha  in  1  1: base forced to alpha (value 2)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  M  result
- busy  out  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - state=IDLE, out_valid=0, out_data=0, busy=0, internal accumulator/exponent/counter=0.
  - in_ready=1 (combinational from state==IDLE, so it is 1 after reset).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch b = in_alpha ? 2 : in_base, e = in_exp; acc=1; cnt=EW; go to RUN.
- RUN (one edge per bit):
  - acc ← sq(acc) then, if e[MSB]=1, multiply by b.
  - Both products are computed combinationally in the same cycle: acc_next = e_msb ? mul(sq(acc), b) : sq(acc).
  - e ← e<<1; cnt ← cnt−1.
  - When cnt reaches 0 on this edge: out_data ← acc_next, out_valid ← 1, go to DONE.
- DONE:
  - out_data and out_valid stay stable while out_ready=0.
  - On out_valid & out_ready: out_valid ← 0, go to IDLE.
  - in_ready stays 0, so a new request is accepted at the earliest one cycle after the output handshake.
- Latency: out_valid rises EW edges after the accepting edge. Throughput is one result per EW+2 cycles.
- Arithmetic:
  - mul is polynomial multiplication mod POLY.
  - sq(x) = mul(x, x).
  - All values are M bits; no result ever exceeds M bits.
- Boundary values:
  - exp=0 → 1, including base=0 (0^0 defined as 1).
  - base=0, exp≠0 → 0.
  - For base≠0 and M=EW, exp=2^M−1 → 1.
- in_valid while not in IDLE is ignored; it is not queued.
- Reset asserted in RUN or DONE aborts the operation: no out_valid pulse, state returns to IDLE on that edge.
- in_* inputs may change freely after the accepting edge.

Optional Feature:
- Macro: GF_POW_ZERO_SKIP_EN.
- Defined:
  - On accept, leading zeros of in_exp are skipped: e is pre-shifted left by lz and cnt = EW−lz.
  - exp=0 goes straight to DONE with out_data=1, so out_valid rises 1 edge after accept.
  - Latency = bit length of exp (min 1).
- Not defined: fixed latency of EW edges for every request.
- Results are identical in both builds.

Decomposition:
- Package gf_pkg holds:
  - state enum (IDLE/RUN/DONE),
  - default POLY constant 9'h11D,
  - generator constant ALPHA=2.
- One sub-module, gf_mul (combinational, parameters M and POLY, ports a, b, p). Instantiated twice: once as the squarer (a=b=acc), once as the multiplier (sq result × b).

Test Plan:
- Reset, then in_alpha=1, exp=8'h10, out_ready=1 → out_data=8'h4C, with out_valid rising 8 edges after accept.
- base=8'h03, exp=8'h03 → 8'h0F. Then base=8'h03, exp=8'h02 → 8'h05.
- Boundaries:
  - base=8'h00, exp=8'h00 → 8'h01;
  - base=8'h00, exp=8'h05 → 8'h00;
  - in_alpha=1, exp=8'hFF → 8'h01;
  - in_alpha=1, exp=8'h08 → 8'h1D.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid; toggle in_valid → out_data stable, in_ready=0, the extra request is not accepted, and exactly one handshake completes.
- Reset asserted 3 edges into RUN → out_valid never pulses; in_ready=1 on the next cycle; a following request alpha^9 → 8'h3A.
- With GF_POW_ZERO_SKIP_EN:
  - exp=8'h00 → result 1 after 1 edge;
  - exp=8'h03 (alpha) → 8'h08 after 2 edges.
- Without the macro, both of those cases take 8 edges.
